lsmitll_pulse_pattern_tx: RTL

Synchronous pulse-pattern transmitter for RSFQ behavioural benches and composite cells. It drives the data input of clocked cells such as the always-0 and DFF-type sync gates. A WIDTH-bit pattern is loaded, then one bit is emitted per clock pulse: a 1 produces a data pulse DELAY_PS after that clock pulse, and a 0 produces none. The block provides the "sender" end of the clocked data interface, so it can exercise receivers cycle by cycle.

---
 rtl/lsmitll_tx_pkg.sv | 17 +
 rtl/lsmitll_pulse_delay.sv | 34 +++
 rtl/lsmitll_pulse_pattern_tx.sv | 102 ++++++++++
 3 files changed

// File: rtl/lsmitll_tx_pkg.sv
// Shared types and default timing constants for the pulse-pattern transmitter.
`default_nettype none
`timescale 1ps/100fs

package lsmitll_tx_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

   localparam int DEFAULT_DELAY_PS      = 10;
   localparam int DEFAULT_MIN_PERIOD_PS = 15;

endpackage : lsmitll_tx_pkg

`default_nettype wire

// File: rtl/lsmitll_pulse_delay.sv
// Turns each transition of req_i into a transition of out_o DELAY_PS later;
// a low rst_ni cancels any pending transition and forces the output to 0.
`default_nettype none
`timescale 1ps/100fs

module lsmitll_pulse_delay #(
   parameter int DELAY_PS = 10
) (
   input  logic req_i,
   input  logic rst_ni,
   output logic out_o
);

   logic out_q = 1'b0;

   // Requests never arrive closer than DELAY_PS, so one pending toggle at a time suffices.
   always begin : p_delay
      @(req_i or negedge rst_ni);
      if (rst_ni) begin
         for (int k = 0; k < DELAY_PS; k++) begin
            if (!rst_ni) break;
            #1;
         end
         out_q <= rst_ni ? ~out_q : 1'b0;
      end else begin
         out_q <= 1'b0;
      end
   end

   assign out_o = out_q & rst_ni;

endmodule : lsmitll_pulse_delay

`default_nettype wire

// File: rtl/lsmitll_pulse_pattern_tx.sv
// RSFQ-style pattern sender: every clk transition shifts out one bit, a 1 becoming
// a q transition DELAY_PS later; done toggles alongside the final bit.
`default_nettype none
`timescale 1ps/100fs

module lsmitll_pulse_pattern_tx
   import lsmitll_tx_pkg::*;
#(
   parameter int WIDTH         = 16,
   parameter int DELAY_PS      = DEFAULT_DELAY_PS,
   parameter int MIN_PERIOD_PS = DEFAULT_MIN_PERIOD_PS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [WIDTH-1:0]           pattern,
   input  logic [$clog2(WIDTH+1)-1:0] len,
   output logic                       q,
   output logic                       done,
   output logic                       busy
);

   localparam int CW = $clog2(WIDTH+1);

   tx_state_e        state_q;
   logic [WIDTH-1:0] shift_q;
   logic [CW-1:0]    count_q;
   logic             busy_q;
   logic             q_req_q;
   logic             done_req_q;
   logic [CW-1:0]    len_sat_d;

   assign len_sat_d = (len > CW'(WIDTH)) ? CW'(WIDTH) : len;

   // Both clock edges are pulses.
   always_ff @(posedge clk or negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         q_req_q    <= 1'b0;
         done_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (load && (len != '0)) begin
                  shift_q <= pattern;
                  count_q <= len_sat_d;
                  busy_q  <= 1'b1;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (shift_q[0]) q_req_q <= ~q_req_q;
               shift_q <= shift_q >> 1;
               count_q <= count_q - 1'b1;
               if (count_q == CW'(1)) begin
                  done_req_q <= ~done_req_q;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;

   lsmitll_pulse_delay #(.DELAY_PS(DELAY_PS)) u_q_delay (
      .req_i  (q_req_q),
      .rst_ni (rst_n),
      .out_o  (q)
   );

   lsmitll_pulse_delay #(.DELAY_PS(DELAY_PS)) u_done_delay (
      .req_i  (done_req_q),
      .rst_ni (rst_n),
      .out_o  (done)
   );

   // Period monitor: reports but never blocks a too-early pulse.
   time  last_pulse_q;
   logic seen_q;

   always_ff @(posedge clk or negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen_q       <= 1'b0;
         last_pulse_q <= '0;
      end else begin
         if (seen_q && (($time - last_pulse_q) < time'(MIN_PERIOD_PS)))
            $display("%m: clock timing violation at %0t ps: spacing %0t ps < %0d ps",
                     $time, $time - last_pulse_q, MIN_PERIOD_PS);
         last_pulse_q <= $time;
         seen_q       <= 1'b1;
      end
   end

endmodule : lsmitll_pulse_pattern_tx

`default_nettype wire
